// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit frame engine.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int unsigned MIN_DATA_BITS  = 5;
  localparam int unsigned MAX_FRAME_BITS = 12;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
`ifdef UART_TX_BREAK_EN
    ,
    BREAK
`endif
  } state_e;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int unsigned max_bits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (32'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

  function automatic logic [3:0] frame_len(input logic [3:0] nbits, input logic par_en,
                                           input logic two_stop);
    return 4'd2 + nbits + {3'b000, par_en} + {3'b000, two_stop};
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Payload handshake between the TX holding register (master) and the frame engine (slave).
interface uart_tx_framer_if #(
  parameter int unsigned DATA_MAX = 8
);
  logic [DATA_MAX-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..div while enabled, pulsing btu on the terminal count.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             btu
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign btu = en && (cnt_q == div);

  always_comb begin
    cnt_d = '0;
    if (en && !btu) cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit frame engine: 5..DATA_MAX data bits, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and line-break generation.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_MAX = 8,
  parameter int unsigned DIV_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic             send_break,
`endif
  uart_tx_framer_if.slave  txb,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_idx
);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [3:0]          nbits_q, nbits_d;
  logic [3:0]          idx_q, idx_d;
  logic [DATA_MAX-1:0] sh_q, sh_d;
  logic                pen_q, pen_d;
  logic                par_q, par_d;
  logic                two_q, two_d;
  logic                tx_q, tx_d;
  logic [3:0]          nb;
  logic                par_new;
  logic                btu;
`ifdef UART_TX_BREAK_EN
  logic [3:0]          len_q, len_d;
`endif

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .div (div_q),
    .btu (btu)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    nbits_d = nbits_q;
    sh_d    = sh_q;
    pen_d   = pen_q;
    par_d   = par_q;
    two_d   = two_q;
    done    = 1'b0;
`ifdef UART_TX_BREAK_EN
    len_d   = len_q;
`endif
    nb      = clamp_bits(data_bits, DATA_MAX);
    par_new = parity_odd;
    for (int unsigned i = 0; i < DATA_MAX; i++) begin
      if (i < 32'(nb)) par_new = par_new ^ txb.tx_data[i];
    end

    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        // A break reuses STOP1 (forced single stop) as its mark-after-break bit.
        if (send_break) begin
          state_d = BREAK;
          div_d   = baud_div;
          two_d   = 1'b0;
          len_d   = frame_len(nb, parity_en, two_stop);
        end else
`endif
        if (txb.tx_valid) begin
          state_d = START;
          div_d   = baud_div;
          nbits_d = nb;
          sh_d    = txb.tx_data;
          pen_d   = parity_en;
          par_d   = par_new;
          two_d   = two_stop;
        end
      end
      START:  if (btu) state_d = DATA;
      DATA: begin
        if (btu) begin
          sh_d = sh_q >> 1;
          if (idx_q == nbits_q) state_d = pen_q ? PARITY : STOP1;
        end
      end
      PARITY: if (btu) state_d = STOP1;
      STOP1: begin
        if (btu) begin
          if (two_q) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
      end
      STOP2: begin
        if (btu) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK:  if (btu && (idx_q == len_q - 4'd1)) state_d = STOP1;
`endif
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) idx_d = '0;
    else if (btu)        idx_d = idx_q + 4'd1;
    else                 idx_d = idx_q;

    // tx is registered from the next state so the start bit appears on the accept edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_d;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = 1'b0;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      nbits_q <= 4'(MIN_DATA_BITS);
      idx_q   <= '0;
      sh_q    <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      two_q   <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_BREAK_EN
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      two_q   <= two_d;
      tx_q    <= tx_d;
`ifdef UART_TX_BREAK_EN
      len_q   <= len_d;
`endif
    end
  end

  assign txb.tx_ready = (state_q == IDLE);
  assign tx           = tx_q;
  assign busy         = (state_q != IDLE);
  assign bit_idx      = idx_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: frame table plus handshake, reset and break sequences.
module tb_uart_tx_framer;

  typedef struct {
    int          div;
    logic [3:0]  db;
    logic        pen;
    logic        podd;
    logic        two;
    logic [7:0]  data;
    int          exp_len;
    logic [11:0] exp_bits;
  } row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic        parity_en, parity_odd, two_stop;
  logic        tx, busy, done;
  logic [3:0]  bit_idx;
`ifdef UART_TX_BREAK_EN
  logic        send_break;
`endif

  int checks = 0;
  int errors = 0;
  row_t rows[14];

  uart_tx_framer_if #(.DATA_MAX(8)) bus ();

  uart_tx_framer #(.DATA_MAX(8), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .txb        (bus),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .bit_idx    (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: list the frame bits from the framing rules, then read them back as a vector.
  function automatic void model(input logic [3:0] dbits, input logic pen, input logic podd,
                                input logic two, input logic [7:0] d,
                                output int len, output logic [11:0] bits);
    int nb;
    int ones;
    int q[$];
    nb   = (dbits < 5) ? 5 : ((dbits > 8) ? 8 : int'(dbits));
    ones = 0;
    q.push_back(0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(int'(d[i]));
      ones += int'(d[i]);
    end
    if (pen) q.push_back((ones % 2) ^ int'(podd));
    q.push_back(1);
    if (two) q.push_back(1);
    len  = q.size();
    bits = '0;
    for (int i = 0; i < len; i++) bits[i] = q[i][0];
  endfunction

  task automatic offer(input row_t r);
    baud_div     = 16'(r.div);
    data_bits    = r.db;
    parity_en    = r.pen;
    parity_odd   = r.podd;
    two_stop     = r.two;
    bus.tx_data  = r.data;
    bus.tx_valid = 1'b1;
  endtask

  task automatic scramble();
    baud_div    = 16'($urandom);
    data_bits   = 4'($urandom);
    parity_en   = 1'($urandom);
    parity_odd  = 1'($urandom);
    two_stop    = 1'($urandom);
    bus.tx_data = 8'($urandom);
  endtask

  // Called at the sample just after the accept edge; returns at the done sample.
  task automatic check_frame(input row_t r);
    int n;
    int b;
    n = r.exp_len * (r.div + 1);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      b = k / (r.div + 1);
      chk("tx_bit", tx, r.exp_bits[b]);
      chk("bit_idx", bit_idx, b);
      chk("done", done, (k == n - 1));
      chk("busy", busy, 1);
      chk("tx_ready_busy", bus.tx_ready, 0);
    end
  endtask

  task automatic check_idle();
    chk("idle_tx", tx, 1);
    chk("idle_ready", bus.tx_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_idx", bit_idx, 0);
  endtask

  task automatic run_frame(input row_t r);
    @(negedge clk);
    offer(r);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    scramble();
    check_frame(r);
    @(posedge clk);
    #1;
    check_idle();
  endtask

  initial begin
    row_t v1, v2;
    logic done_seen;

    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    baud_div     = '0;
    data_bits    = 4'd8;
    parity_en    = 1'b0;
    parity_odd   = 1'b0;
    two_stop     = 1'b0;
`ifdef UART_TX_BREAK_EN
    send_break   = 1'b0;
`endif
    #2;
    check_idle();

    rows[0] = '{div:3, db:4'd8,  pen:1'b0, podd:1'b0, two:1'b0, data:8'hA5, exp_len:10, exp_bits:12'h34A};
    rows[1] = '{div:0, db:4'd7,  pen:1'b1, podd:1'b0, two:1'b1, data:8'h41, exp_len:11, exp_bits:12'h682};
    rows[2] = '{div:1, db:4'd5,  pen:1'b1, podd:1'b1, two:1'b0, data:8'h1F, exp_len:8,  exp_bits:12'h0BE};
    rows[3] = '{div:0, db:4'd2,  pen:1'b0, podd:1'b0, two:1'b0, data:8'h35, exp_len:7,  exp_bits:12'h06A};
    rows[4] = '{div:1, db:4'd15, pen:1'b1, podd:1'b0, two:1'b1, data:8'hFF, exp_len:12, exp_bits:12'hDFE};
    rows[5] = '{div:2, db:4'd6,  pen:1'b1, podd:1'b1, two:1'b1, data:8'h00, exp_len:10, exp_bits:12'h380};
    for (int i = 6; i < 14; i++) begin
      rows[i].div  = int'($urandom_range(0, 3));
      rows[i].db   = 4'($urandom_range(0, 15));
      rows[i].pen  = 1'($urandom_range(0, 1));
      rows[i].podd = 1'($urandom_range(0, 1));
      rows[i].two  = 1'($urandom_range(0, 1));
      rows[i].data = 8'($urandom);
      model(rows[i].db, rows[i].pen, rows[i].podd, rows[i].two, rows[i].data,
            rows[i].exp_len, rows[i].exp_bits);
    end

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) run_frame(rows[i]);

    // Back-to-back: tx_valid stays high; next accept lands on the first IDLE cycle.
    v1 = '{div:1, db:4'd8, pen:1'b0, podd:1'b0, two:1'b0, data:8'h3C, exp_len:0, exp_bits:'0};
    v2 = '{div:1, db:4'd6, pen:1'b1, podd:1'b0, two:1'b0, data:8'hC3, exp_len:0, exp_bits:'0};
    model(v1.db, v1.pen, v1.podd, v1.two, v1.data, v1.exp_len, v1.exp_bits);
    model(v2.db, v2.pen, v2.podd, v2.two, v2.data, v2.exp_len, v2.exp_bits);
    @(negedge clk);
    offer(v1);
    @(posedge clk);
    #1;
    check_frame(v1);
    offer(v2);
    @(posedge clk);
    #1;
    chk("b2b_gap_tx", tx, 1);
    chk("b2b_gap_ready", bus.tx_ready, 1);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    check_frame(v2);
    @(posedge clk);
    #1;
    check_idle();

    // Reset during DATA bit 3 (frame bit 4) of an 8N1, div=3 frame.
    @(negedge clk);
    offer(rows[0]);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("pre_reset_idx", bit_idx, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | done;
    end
    chk("rst_no_done", done_seen, 0);
    check_idle();

`ifdef UART_TX_BREAK_EN
    // Break with 8N1, div=1: 20 clocks low, 2 clocks mark, done on the last; valid waits.
    @(negedge clk);
    offer(v1);
    send_break = 1'b1;
    @(posedge clk);
    #1;
    send_break = 1'b0;
    scramble();
    bus.tx_data = v2.data;
    for (int k = 0; k < 22; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("brk_tx", tx, (k >= 20));
      chk("brk_done", done, (k == 21));
      chk("brk_ready", bus.tx_ready, 0);
    end
    offer(v2);
    @(posedge clk);
    #1;
    check_idle();
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    check_frame(v2);
    @(posedge clk);
    #1;
    check_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
